// File: rtl/bus_pkg.sv
// Shared definitions for bus-transfer sequencing: op-codes, FSM encoding and
// helpers classifying which side of the bus an op uses.
package bus_pkg;

  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_LATCH = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  // A register drives the bus for MOV and STORE.
  function automatic logic op_reads_reg(input logic [1:0] op);
    return (op == OP_MOV) || (op == OP_STORE);
  endfunction

  // A register captures the bus for MOV and LOAD.
  function automatic logic op_writes_reg(input logic [1:0] op);
    return (op == OP_MOV) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary select to one-hot strobe decoder; all outputs low when not enabled.
module onehot_dec #(
  parameter int SEL_W    = 2,
  parameter int NUM_REGS = 4
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                ena,
  output logic [NUM_REGS-1:0] dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ena && (sel == SEL_W'(i))) dec[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-file bus sequencer: one transfer at a time through a fixed
// drive / latch / hold sequence, with a bus-idle IDLE cycle between transfers.
module reg_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SEL_W-1:0]    req_src,
  input  logic [SEL_W-1:0]    req_dst,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] en,
  output logic [NUM_REGS-1:0] cs,
  output logic                ext_oe,
  output logic                ext_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t           state, state_nx;
  logic [1:0]       op_q;
  logic [SEL_W-1:0] src_q, dst_q;
  logic             err_q;
  logic             accept, reject, src_oob, dst_oob;
  logic             oe_ena, en_ena;

  // Request classification; only selects the op actually uses can reject it.
  always_comb begin
    src_oob = 32'(req_src) >= NUM_REGS;
    dst_oob = 32'(req_dst) >= NUM_REGS;
    reject  = (req_op == OP_RSVD)
            | ((req_op == OP_MOV) && (req_src == req_dst))
            | (op_reads_reg(req_op) && src_oob)
            | (op_writes_reg(req_op) && dst_oob);
  end

  assign accept = req_valid && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && reject;
    end
  end

  // Selects are only meaningful outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && !reject) begin
      op_q  <= req_op;
      src_q <= req_src;
      dst_q <= req_dst;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    oe_ena    = 1'b0;
    en_ena    = 1'b0;
    ext_oe    = 1'b0;
    ext_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid && !reject) state_nx = ST_DRIVE;
      end
      ST_DRIVE: begin
        oe_ena   = op_reads_reg(op_q);
        ext_oe   = (op_q == OP_LOAD);
        state_nx = ST_LATCH;
      end
      ST_LATCH: begin
        // Destination captures on the edge that ends this state.
        oe_ena   = op_reads_reg(op_q);
        ext_oe   = (op_q == OP_LOAD);
        en_ena   = op_writes_reg(op_q);
        ext_en   = (op_q == OP_STORE);
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        oe_ena   = op_reads_reg(op_q);
        ext_oe   = (op_q == OP_LOAD);
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_oe_dec (
    .sel (src_q),
    .ena (oe_ena),
    .dec (oe)
  );

  onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_en_dec (
    .sel (dst_q),
    .ena (en_ena),
    .dec (en)
  );

  assign cs  = oe | en;
  assign err = err_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: directed scenarios plus a randomized
// run against a per-cycle expected-output schedule model.
module tb_reg_xfer_ctrl;
  import bus_pkg::*;

  localparam int NR = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready;
  logic [1:0]    req_op;
  logic [SW-1:0] req_src, req_dst;
  logic [NR-1:0] oe, en, cs;
  logic          ext_oe, ext_en, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [17:0] obs;
  assign obs = {oe, en, cs, ext_oe, ext_en, busy, done, err, req_ready};

  reg_xfer_ctrl #(.NUM_REGS(NR), .SEL_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .oe        (oe),
    .en        (en),
    .cs        (cs),
    .ext_oe    (ext_oe),
    .ext_en    (ext_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Expected output bundle; cs is oe|en and req_ready is the inverse of busy.
  function automatic logic [17:0] mk(input logic [3:0] o, input logic [3:0] e,
                                     input logic xo, input logic xe, input logic b,
                                     input logic d, input logic er);
    return {o, e, o | e, xo, xe, b, d, er, ~b};
  endfunction

  localparam logic [17:0] IDLE_EXP = 18'b000000000000_000001;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [1:0] op,
                           input logic [SW-1:0] s, input logic [SW-1:0] d);
    req_valid = v;
    req_op    = op;
    req_src   = s;
    req_dst   = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b0, OP_MOV, '0, '0);
    next();
    next();
    checks++;
    if (obs !== IDLE_EXP) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, IDLE_EXP);
    end
    reset = 1'b0;
    next();
    checks++;
    if (obs !== IDLE_EXP) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, IDLE_EXP);
    end
  endtask

  task automatic test_mov();
    logic [17:0] e;
    drive_req(1'b1, OP_MOV, 3'd1, 3'd2);
    checks++;
    if (obs !== IDLE_EXP) begin
      errors++;
      $display("FAIL mov_c0 got=%b exp=%b", obs, IDLE_EXP);
    end
    next();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1:       e = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 0);
        2:       e = mk(4'b0010, 4'b0100, 0, 0, 1, 0, 0);
        3:       e = mk(4'b0010, 4'b0000, 0, 0, 1, 1, 0);
        default: e = IDLE_EXP;
      endcase
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mov_c%0d got=%b exp=%b", c, obs, e);
      end
      next();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    drive_req(1'b1, OP_LOAD, 3'd0, 3'd3);
    next();
    drive_req(1'b1, OP_STORE, 3'd3, 3'd0);
    for (int c = 1; c <= 8; c++) begin
      case (c)
        1:       e = mk(4'b0000, 4'b0000, 1, 0, 1, 0, 0);
        2:       e = mk(4'b0000, 4'b1000, 1, 0, 1, 0, 0);
        3:       e = mk(4'b0000, 4'b0000, 1, 0, 1, 1, 0);
        5:       e = mk(4'b1000, 4'b0000, 0, 0, 1, 0, 0);
        6:       e = mk(4'b1000, 4'b0000, 0, 1, 1, 0, 0);
        7:       e = mk(4'b1000, 4'b0000, 0, 0, 1, 1, 0);
        default: e = IDLE_EXP;
      endcase
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_c%0d got=%b exp=%b", c, obs, e);
      end
      if (c == 5) req_valid = 1'b0;
      next();
    end
  endtask

  task automatic test_rejects();
    logic [1:0]    ops [4] = '{OP_MOV, OP_RSVD, OP_LOAD, OP_STORE};
    logic [SW-1:0] srcs[4] = '{3'd0, 3'd1, 3'd0, 3'd6};
    logic [SW-1:0] dsts[4] = '{3'd0, 3'd2, 3'd5, 3'd1};
    logic [17:0]   e_err;
    e_err = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, ops[i], srcs[i], dsts[i]);
      checks++;
      if (obs !== IDLE_EXP) begin
        errors++;
        $display("FAIL rej%0d_c0 got=%b exp=%b", i, obs, IDLE_EXP);
      end
      next();
      req_valid = 1'b0;
      checks++;
      if (obs !== e_err) begin
        errors++;
        $display("FAIL rej%0d_err got=%b exp=%b", i, obs, e_err);
      end
      next();
      checks++;
      if (obs !== IDLE_EXP) begin
        errors++;
        $display("FAIL rej%0d_after got=%b exp=%b", i, obs, IDLE_EXP);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    drive_req(1'b1, OP_MOV, 3'd0, 3'd1);
    next();
    req_valid = 1'b0;
    e = mk(4'b0001, 4'b0000, 0, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rstmid_drive got=%b exp=%b", obs, e);
    end
    reset = 1'b1;
    next();
    reset = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (obs !== IDLE_EXP) begin
        errors++;
        $display("FAIL rstmid_c%0d got=%b exp=%b", c, obs, IDLE_EXP);
      end
      next();
    end
  endtask

  task automatic test_sel_change();
    logic [17:0] e;
    drive_req(1'b1, OP_MOV, 3'd2, 3'd0);
    next();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1:       e = mk(4'b0100, 4'b0000, 0, 0, 1, 0, 0);
        2:       e = mk(4'b0100, 4'b0001, 0, 0, 1, 0, 0);
        3:       e = mk(4'b0100, 4'b0000, 0, 0, 1, 1, 0);
        default: e = IDLE_EXP;
      endcase
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL selchg_c%0d got=%b exp=%b", c, obs, e);
      end
      req_op  = 2'($urandom_range(0, 3));
      req_src = SW'($urandom_range(0, 7));
      req_dst = SW'($urandom_range(0, 7));
      next();
    end
  endtask

  function automatic logic is_bad(input logic [1:0] op, input logic [SW-1:0] s,
                                  input logic [SW-1:0] d);
    if (op == 2'b11) return 1'b1;
    if (op == 2'b00 && s == d) return 1'b1;
    if ((op == 2'b00 || op == 2'b10) && int'(s) >= NR) return 1'b1;
    if ((op == 2'b00 || op == 2'b01) && int'(d) >= NR) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e;
    logic [3:0]  sv, dv;
    int accepted = 0;
    int cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      e = (q.size() != 0) ? q.pop_front() : IDLE_EXP;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rand_outputs cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      checks++;
      if ($countones(oe) + int'(ext_oe) > 1) begin
        errors++;
        $display("FAIL rand_oe_onehot cyc=%0d oe=%b ext_oe=%b required<=1", cyc, oe, ext_oe);
      end
      checks++;
      if ($countones(en) + int'(ext_en) > 1) begin
        errors++;
        $display("FAIL rand_en_onehot cyc=%0d en=%b ext_en=%b required<=1", cyc, en, ext_en);
      end
      checks++;
      if ((|en || ext_en) && !(|oe || ext_oe)) begin
        errors++;
        $display("FAIL rand_en_without_oe cyc=%0d en=%b ext_en=%b oe=%b ext_oe=%b",
                 cyc, en, ext_en, oe, ext_oe);
      end
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_src   = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
      req_dst   = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(4, 7)) : SW'($urandom_range(0, 3));
      if (reset) begin
        q.delete();
      end else if (req_valid && e[0]) begin
        accepted++;
        if (is_bad(req_op, req_src, req_dst)) begin
          q.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 1));
        end else begin
          sv = (req_op == 2'b01) ? 4'b0000 : 4'(1) << req_src;
          dv = (req_op == 2'b10) ? 4'b0000 : 4'(1) << req_dst;
          q.push_back(mk(sv, 4'b0000, req_op == 2'b01, 1'b0, 1, 0, 0));
          q.push_back(mk(sv, dv, req_op == 2'b01, req_op == 2'b10, 1, 0, 0));
          q.push_back(mk(sv, 4'b0000, req_op == 2'b01, 1'b0, 1, 1, 0));
        end
      end
      next();
      cyc++;
    end
    checks++;
    if (accepted < 1000) begin
      errors++;
      $display("FAIL rand_budget accepted=%0d required=1000 within 20000 cycles", accepted);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    repeat (6) next();
  endtask

  initial begin
    reset = 1'b1;
    drive_req(1'b0, OP_MOV, '0, '0);
    test_reset();
    test_mov();
    test_back_to_back();
    test_rejects();
    test_reset_mid();
    test_sel_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
